// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave: bus widths,
// response codes, FSM state encodings, the address decode and the byte merge.
package axil_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rstate_t;

  // True when addr falls inside [base, base+span). The first term keeps the
  // subtraction from wrapping when addr is below base.
  function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

  // Byte-lane merge: strobed lanes take the new data, the others keep old.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_regfile.sv
// Register storage for the AXI4-Lite slave: byte-strobed writes and a
// one-cycle commit pulse per register, registered alongside the data.
module axil_regfile
  import axil_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic                             we,
  input  logic [IDX_W-1:0]                 widx,
  input  logic [DATA_W-1:0]                wdata,
  input  logic [STRB_W-1:0]                wstrb,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  output logic [NUM_REGS-1:0]              wr_strobe
);

  // NOTE: this storage is reset because every register must read zero after
  // reset; plain RAM-style arrays normally get no reset so they map to memory.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      regs      <= '0;
      wr_strobe <= '0;
    end else begin
      wr_strobe <= '0;
      if (we) begin
        regs[widx]      <= merge_bytes(regs[widx], wdata, wstrb);
        wr_strobe[widx] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_lite_s.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers at BASE_ADDR.
// Independent write and read FSMs; storage lives in axil_regfile.
module axis_lite_s
  import axil_pkg::*;
#(
  parameter int                NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'haaaa_bb00
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [ADDR_W-1:0]        s_axi_awaddr,
  input  logic [2:0]               s_axi_awprot,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [DATA_W-1:0]        s_axi_wdata,
  input  logic [STRB_W-1:0]        s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [ADDR_W-1:0]        s_axi_araddr,
  input  logic [2:0]               s_axi_arprot,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [DATA_W-1:0]        s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic [NUM_REGS*32-1:0]   app_regs,
  output logic [NUM_REGS-1:0]      app_wr_strobe
);

  localparam int                IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4 * NUM_REGS);

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  logic unused_prot;
  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  // Readies stay low until the first clock edge after reset is released.
  logic ready_en;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  // ---------------- write path ----------------
  wstate_t           wstate, wstate_nxt;
  logic              aw_full, w_full;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  resp_t             bresp_q;
  logic              commit, b_done;
  logic              wr_hit;
  logic [IDX_W-1:0]  wr_idx;

  assign wr_hit = addr_hit(aw_addr_q, BASE_ADDR, SPAN);
  assign wr_idx = addr_index(aw_addr_q);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    wstate_nxt    = wstate;
    commit        = 1'b0;
    b_done        = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    case (wstate)
      W_IDLE: begin
        s_axi_awready = ready_en && !aw_full;
        s_axi_wready  = ready_en && !w_full;
        if (aw_full && w_full) begin
          commit     = 1'b1;
          wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          b_done     = 1'b1;
          wstate_nxt = W_IDLE;
        end
      end
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wstate    <= W_IDLE;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= OKAY;
    end else begin
      wstate <= wstate_nxt;
      if (b_done) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end else begin
        if (s_axi_awvalid && s_axi_awready) begin
          aw_full   <= 1'b1;
          aw_addr_q <= s_axi_awaddr;
        end
        if (s_axi_wvalid && s_axi_wready) begin
          w_full   <= 1'b1;
          w_data_q <= s_axi_wdata;
          w_strb_q <= s_axi_wstrb;
        end
      end
      if (commit) bresp_q <= wr_hit ? OKAY : SLVERR;
    end
  end

  assign s_axi_bvalid = (wstate == W_RESP);
  assign s_axi_bresp  = bresp_q;

  axil_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .aclk      (aclk),
    .areset    (areset),
    .we        (commit && wr_hit),
    .widx      (wr_idx),
    .wdata     (w_data_q),
    .wstrb     (w_strb_q),
    .regs      (regs),
    .wr_strobe (app_wr_strobe)
  );

  assign app_regs = regs;

  // ---------------- read path ----------------
  rstate_t           rstate, rstate_nxt;
  logic              ar_take;
  logic              rd_hit;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rdata_q;
  resp_t             rresp_q;

  assign rd_hit = addr_hit(s_axi_araddr, BASE_ADDR, SPAN);
  assign rd_idx = addr_index(s_axi_araddr);

  always_comb begin
    rstate_nxt    = rstate;
    ar_take       = 1'b0;
    s_axi_arready = 1'b0;
    case (rstate)
      R_IDLE: begin
        s_axi_arready = ready_en;
        if (ready_en && s_axi_arvalid) begin
          ar_take    = 1'b1;
          rstate_nxt = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axi_rready) rstate_nxt = R_IDLE;
      end
    endcase
  end

  // Sampling regs on the AR edge returns the pre-write value when a write
  // commits on that same edge.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rstate  <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else begin
      rstate <= rstate_nxt;
      if (ar_take) begin
        rdata_q <= rd_hit ? regs[rd_idx] : '0;
        rresp_q <= rd_hit ? OKAY : SLVERR;
      end
    end
  end

  assign s_axi_rvalid = (rstate == R_RESP);
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;

endmodule

// File: tb/tb_axis_lite_s.sv
// Directed self-checking bench for axis_lite_s: reset, write ordering,
// byte strobes, decode errors, read back-pressure, read/write race, reset abort.
module tb_axis_lite_s;

  localparam int NR = 16;

  logic              aclk = 1'b0;
  logic              areset;
  logic [31:0]       s_axi_awaddr;
  logic [2:0]        s_axi_awprot;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [31:0]       s_axi_araddr;
  logic [2:0]        s_axi_arprot;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic [NR*32-1:0]  app_regs;
  logic [NR-1:0]     app_wr_strobe;

  axis_lite_s #(.NUM_REGS(NR), .BASE_ADDR(32'haaaa_bb00)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .app_regs      (app_regs),
    .app_wr_strobe (app_wr_strobe)
  );

  always #5 aclk = ~aclk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_regs [NR];
  int          pulses   [NR];
  logic [1:0]  resp;
  logic [31:0] rdat;

  always @(negedge aclk) begin
    for (int i = 0; i < NR; i++) if (app_wr_strobe[i] === 1'b1) pulses[i]++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++)
      check($sformatf("%s_reg%0d", tag, i), app_regs[32*i +: 32], exp_regs[i]);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] r);
    logic aw_done, w_done, aw_hs, w_hs;
    int   n;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
    s_axi_wdata  = data; s_axi_wstrb   = strb; s_axi_wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      tick();
      if (aw_hs) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; s_axi_wvalid  = 1'b0; end
      n++;
    end
    check("wr_accept", {aw_done, w_done}, 2'b11);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin tick(); n++; end
    check("wr_bvalid", s_axi_bvalid, 1'b1);
    r = s_axi_bresp;
    s_axi_bready = 1'b1; tick(); s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    logic hs, done;
    int   n;
    done = 1'b0; n = 0;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    while (!done && n < 20) begin
      hs = s_axi_arready;
      tick();
      if (hs) done = 1'b1;
      n++;
    end
    s_axi_arvalid = 1'b0;
    check("rd_accept", done, 1'b1);
    n = 0;
    while (!s_axi_rvalid && n < 20) begin tick(); n++; end
    check("rd_rvalid", s_axi_rvalid, 1'b1);
    d = s_axi_rdata; r = s_axi_rresp;
    s_axi_rready = 1'b1; tick(); s_axi_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin exp_regs[i] = '0; pulses[i] = 0; end
    areset = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = 3'b010; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = 3'b101; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_awready", s_axi_awready, 1'b0);
    check("rst_wready",  s_axi_wready,  1'b0);
    check("rst_arready", s_axi_arready, 1'b0);
    check("rst_bvalid",  s_axi_bvalid,  1'b0);
    check("rst_rvalid",  s_axi_rvalid,  1'b0);
    check("rst_resps",   {s_axi_bresp, s_axi_rresp}, 4'b0000);
    check("rst_rdata",   s_axi_rdata,   32'h0);
    check("rst_strobe",  app_wr_strobe, 16'h0);
    check_regs("rst");
    areset = 1'b0;
    #1;
    check("rel_awready_low", s_axi_awready, 1'b0);
    tick();
    check("rel_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    // AW and W in the same cycle
    s_axi_awaddr = 32'haaaa_bb08; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h5aa5_a55a; s_axi_wstrb = 4'hf; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("same_slots_full", {s_axi_awready, s_axi_wready, s_axi_bvalid}, 3'b000);
    tick();
    exp_regs[2] = 32'h5aa5_a55a;
    check("same_bvalid", s_axi_bvalid, 1'b1);
    check("same_bresp",  s_axi_bresp, 2'b00);
    check("same_reg2",   app_regs[2*32 +: 32], exp_regs[2]);
    check("same_strobe", app_wr_strobe, 16'h0004);
    tick();
    check("same_strobe_clear", app_wr_strobe, 16'h0000);
    check("same_bvalid_held",  s_axi_bvalid, 1'b1);
    s_axi_bready = 1'b1; tick(); s_axi_bready = 1'b0;
    check("same_bvalid_drop", s_axi_bvalid, 1'b0);
    check("same_readies_back", {s_axi_awready, s_axi_wready}, 2'b11);
    check("same_pulse_count", pulses[2], 1);

    // W three cycles ahead of AW, partial strobes
    s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'b0101; s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    check("wfirst_wready_low", s_axi_wready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wfirst_no_bvalid", s_axi_bvalid, 1'b0);
    end
    s_axi_awaddr = 32'haaaa_bb04; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    check("wfirst_no_bvalid_aw", s_axi_bvalid, 1'b0);
    tick();
    exp_regs[1] = 32'h0034_0078;
    check("wfirst_bvalid", s_axi_bvalid, 1'b1);
    check("wfirst_reg1",   app_regs[1*32 +: 32], exp_regs[1]);
    check("wfirst_strobe", app_wr_strobe, 16'h0002);
    s_axi_bready = 1'b1; tick(); s_axi_bready = 1'b0;

    // Out-of-range write and read
    axi_write(32'haaaa_bbbb, 32'hffff_ffff, 4'hf, resp);
    check("oor_bresp", resp, 2'b10);
    check_regs("oor_wr");
    axi_read(32'haaaa_bbbb, rdat, resp);
    check("oor_rresp", resp, 2'b10);
    check("oor_rdata", rdat, 32'h0);

    // Read with rready held low
    s_axi_araddr = 32'haaaa_bb08; s_axi_arvalid = 1'b1;
    check("bp_arready", s_axi_arready, 1'b1);
    tick();
    s_axi_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid",  s_axi_rvalid, 1'b1);
      check("bp_rdata",   s_axi_rdata, 32'h5aa5_a55a);
      check("bp_arready_low", s_axi_arready, 1'b0);
      tick();
    end
    check("bp_rresp", s_axi_rresp, 2'b00);
    s_axi_rready = 1'b1; tick(); s_axi_rready = 1'b0;
    check("bp_done", {s_axi_rvalid, s_axi_arready}, 2'b01);

    // Read of reg 3 on the edge its write commits
    s_axi_awaddr = 32'haaaa_bb0c; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hdead_beef; s_axi_wstrb = 4'hf; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_araddr = 32'haaaa_bb0c; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    exp_regs[3] = 32'hdead_beef;
    check("race_bvalid", s_axi_bvalid, 1'b1);
    check("race_rvalid", s_axi_rvalid, 1'b1);
    check("race_old",    s_axi_rdata, 32'h0);
    check("race_reg3",   app_regs[3*32 +: 32], exp_regs[3]);
    s_axi_bready = 1'b1; s_axi_rready = 1'b1; tick();
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    axi_read(32'haaaa_bb0c, rdat, resp);
    check("race_new", rdat, 32'hdead_beef);
    check("race_new_resp", resp, 2'b00);

    // Boundaries: last register, ignored low address bits, just outside
    axi_write(32'haaaa_bb3c, 32'haabb_ccdd, 4'b1000, resp);
    exp_regs[15] = 32'haa00_0000;
    check("last_bresp", resp, 2'b00);
    check("last_pulse", pulses[15], 1);
    axi_read(32'haaaa_bb3f, rdat, resp);
    check("last_rd", rdat, 32'haa00_0000);
    axi_write(32'haaaa_bb40, 32'h0bad_0bad, 4'hf, resp);
    check("above_bresp", resp, 2'b10);
    axi_read(32'haaaa_bafc, rdat, resp);
    check("below_rresp", resp, 2'b10);
    check("below_rdata", rdat, 32'h0);
    check_regs("bounds");

    // Reset while a write response waits for bready
    s_axi_awaddr = 32'haaaa_bb14; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h1111_2222; s_axi_wstrb = 4'hf; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    tick();
    check("abort_bvalid_pre", s_axi_bvalid, 1'b1);
    check("abort_reg5_pre",   app_regs[5*32 +: 32], 32'h1111_2222);
    tick();
    areset = 1'b1;
    #1;
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
    check("abort_bvalid", s_axi_bvalid, 1'b0);
    check("abort_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    check("abort_bresp", s_axi_bresp, 2'b00);
    check_regs("abort");
    s_axi_bready = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
    #1;
    check("abort_rel_readies_low", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    tick();
    check("abort_rel_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_late_resp", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
      tick();
    end
    s_axi_bready = 1'b0;
    check_regs("abort_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_lite_s.md
AXIS_LITE_S -- requirements
Module: axis_lite_s

Interface
REQ-001 Parameter NUM_REGS, 16, number of 32-bit registers (2..64).
REQ-002 Parameter BASE_ADDR, 32'haaaa_bb00, byte address of register 0; shall be aligned to 4*NUM_REGS.
REQ-003 aclk  in  1  sole clock; all logic on rising edge.
REQ-004 areset  in  1  reset, asynchronous, active-high.
REQ-005 s_axi_awaddr  in  32  write address.
REQ-006 s_axi_awprot  in  3  accepted, ignored.
REQ-007 s_axi_awvalid  in  1  write address valid.
REQ-008 s_axi_awready  out  1  write address ready.
REQ-009 s_axi_wdata  in  32  write data.
REQ-010 s_axi_wstrb  in  4  byte enables; bit n covers wdata[8n+7:8n].
REQ-011 s_axi_wvalid  in  1  write data valid.
REQ-012 s_axi_wready  out  1  write data ready.
REQ-013 s_axi_bresp  out  2  write response.
REQ-014 s_axi_bvalid  out  1  write response valid.
REQ-015 s_axi_bready  in  1  write response ready.
REQ-016 s_axi_araddr  in  32  read address.
REQ-017 s_axi_arprot  in  3  accepted, ignored.
REQ-018 s_axi_arvalid  in  1  read address valid.
REQ-019 s_axi_arready  out  1  read address ready.
REQ-020 s_axi_rdata  out  32  read data.
REQ-021 s_axi_rresp  out  2  read response.
REQ-022 s_axi_rvalid  out  1  read data valid.
REQ-023 s_axi_rready  in  1  read data ready.
REQ-024 app_regs  out  NUM_REGS*32  register contents; reg i at [32i+31:32i].
REQ-025 app_wr_strobe  out  NUM_REGS  one-cycle pulse on bit i when reg i is committed.

Function
REQ-026 Decode: address in range iff BASE_ADDR <= addr < BASE_ADDR+4*NUM_REGS; index = (addr-BASE_ADDR)>>2; addr[1:0] ignored.
REQ-027 Responses: OKAY=2'b00 in range, SLVERR=2'b10 out of range; out-of-range write modifies nothing, out-of-range read returns rdata=0.
REQ-028 Write FSM states W_IDLE, W_RESP; AW and W captured independently, either order or same cycle; awready (wready) high in W_IDLE while its slot is empty, low otherwise.
REQ-029 Cycle after both slots are full: bytes with wstrb=1 written, wstrb=0 bytes kept, app_wr_strobe[index] pulses (even if wstrb=0), bvalid=1, bresp set, state W_RESP.
REQ-030 W_RESP: bvalid and bresp held until bvalid&bready; at that edge both slots clear and state returns W_IDLE; next AW/W accepted from following cycle.
REQ-031 Read FSM states R_IDLE, R_RESP; arready=1 only in R_IDLE; on arvalid&arready, rdata/rresp registered, rvalid=1 next cycle, state R_RESP.
REQ-032 R_RESP: rvalid, rdata, rresp held stable until rvalid&rready, then R_IDLE; minimum read throughput one per 2 cycles.
REQ-033 Read and write paths fully independent; AR handshake on same edge as write commit to same register returns the pre-write value.
REQ-034 app_regs reflect a write from the cycle bvalid rises.

Reset
REQ-035 While areset=1: all registers 0, all ready/valid outputs 0, bresp/rresp/rdata 0, app_wr_strobe 0, both FSMs idle, slots empty.
REQ-036 Reset mid-transaction aborts it; no response issued afterwards; readies rise on first aclk edge after areset falls.

Structure
REQ-037 Package axil_pkg holds ADDR_W=32, DATA_W=32, resp_t with OKAY/SLVERR, write and read state enums.
REQ-038 Sub-module axil_regfile implements storage, byte-strobe write and strobe pulses; axis_lite_s holds the handshake FSMs.

Verification
REQ-039 AW 32'haaaa_bb08 and W 32'h5aa5_a55a strb 4'hf same cycle -> bresp OKAY, app_regs[2]=32'h5aa5_a55a, app_wr_strobe[2] pulses once.
REQ-040 W (32'h1234_5678, strb 4'b0101) 3 cycles before AW 32'haaaa_bb04 -> reg1 = 32'h0034_0078 from 0; no bvalid before AW.
REQ-041 Write to 32'haaaa_bbbb -> bresp SLVERR, no reg change; read 32'haaaa_bbbb -> rresp SLVERR, rdata 0.
REQ-042 Read 32'haaaa_bb08 with rready low 5 cycles -> rvalid and rdata 32'h5aa5_a55a held stable; arready low until handshake.
REQ-043 Concurrent write 32'hdead_beef to reg 3 with read of reg 3 on commit edge -> read returns old value, later read returns 32'hdead_beef.
REQ-044 areset asserted while bvalid=1 awaiting bready -> bvalid 0 immediately, all app_regs 0, no late response after release.
